// File: rtl/act_buf_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// act_buf_pkg: reader states and address-width default shared by the
// activation buffer and its bank controller.             Rev 1.0
// ------------------------------------------------------------------
package act_buf_pkg;

  localparam int DEF_ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/act_bank_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// act_bank_ctrl: ping/pong ownership of the two activation banks,
// host write gating and tile read streaming.             Rev 1.0
// ------------------------------------------------------------------
module act_bank_ctrl
  import act_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_waddr,
  input  logic                  host_commit,
  output logic                  host_wr_ready,
  output logic                  buf_we,
  output logic [ADDR_WIDTH-1:0] buf_waddr,
  output logic                  buf_bank_sel_wr,
  input  logic [ADDR_WIDTH:0]   cfg_k_len,
  input  logic                  arr_ready,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] k_idx,
  output logic                  bank_sel_rd,
  output logic                  a_valid,
  output logic                  tile_done,
  output logic                  err_overflow
);

  localparam logic [ADDR_WIDTH:0] MAX_K_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  rd_state_e             state_q;
  logic [1:0]            full_cnt_q, full_cnt_d;
  logic                  wr_bank_q, rd_bank_q;
  logic [ADDR_WIDTH-1:0] k_idx_q, k_last_q;
  logic [1:0]            vld_q;
  logic                  err_q;

  logic                  w_start, w_tile_start, w_release, w_commit_ok;
  logic [ADDR_WIDTH-1:0] w_k_last;

  assign host_wr_ready   = (full_cnt_q != 2'd2);
  assign buf_we          = host_we & host_wr_ready;
  assign buf_waddr       = host_waddr;
  assign buf_bank_sel_wr = wr_bank_q;

  assign w_commit_ok  = host_commit & host_wr_ready;
  assign w_start      = (state_q == IDLE) && (full_cnt_q != 2'd0) && arr_ready;
  assign w_tile_start = w_start && (cfg_k_len != '0);
  // A zero-length tile has nothing to read, so its bank is handed back at once.
  assign w_release    = (state_q == DRAIN) || (w_start && (cfg_k_len == '0));

  // Index of the last row; an oversized length clamps to the full bank depth.
  assign w_k_last = (cfg_k_len > MAX_K_LEN) ? '1 : (cfg_k_len[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1));

  always_comb begin
    full_cnt_d = full_cnt_q;
    case ({w_commit_ok, w_release})
      2'b10:   full_cnt_d = full_cnt_q + 2'd1;
      2'b01:   full_cnt_d = full_cnt_q - 2'd1;
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      full_cnt_q <= 2'd0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      k_idx_q    <= '0;
      k_last_q   <= '0;
      vld_q      <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      full_cnt_q <= full_cnt_d;
      if (w_commit_ok)
        wr_bank_q <= ~wr_bank_q;
      if (w_release)
        rd_bank_q <= ~rd_bank_q;
      if ((host_we || host_commit) && !host_wr_ready)
        err_q <= 1'b1;
      // Row i is read in STREAM cycle n+i and reaches a_vec two edges later.
      vld_q <= {vld_q[0], (state_q == STREAM)};

      case (state_q)
        IDLE: begin
          if (w_tile_start) begin
            state_q  <= STREAM;
            k_idx_q  <= '0;
            k_last_q <= w_k_last;
          end
        end
        STREAM: begin
          if (k_idx_q == k_last_q)
            state_q <= DRAIN;
          else
            k_idx_q <= k_idx_q + ADDR_WIDTH'(1);
        end
        DRAIN: begin
          state_q <= IDLE;
          k_idx_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The extra DRAIN read clocks the last row out of the gated buffer.
  assign rd_en        = (state_q == STREAM) || (state_q == DRAIN);
  assign k_idx        = k_idx_q;
  assign bank_sel_rd  = rd_bank_q;
  assign a_valid      = vld_q[1];
  assign tile_done    = w_release;
  assign err_overflow = err_q;

endmodule
`default_nettype wire

// File: tb/tb_act_bank_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_act_bank_ctrl: scoreboard bench for the activation bank
// controller.                                            Rev 1.0
// ------------------------------------------------------------------
module tb_act_bank_ctrl;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_waddr = '0;
  logic          host_commit = 1'b0;
  logic          host_wr_ready;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic          buf_bank_sel_wr;
  logic [AW:0]   cfg_k_len = '0;
  logic          arr_ready = 1'b0;
  logic          rd_en;
  logic [AW-1:0] k_idx;
  logic          bank_sel_rd;
  logic          a_valid;
  logic          tile_done;
  logic          err_overflow;

  act_bank_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .host_we        (host_we),
    .host_waddr     (host_waddr),
    .host_commit    (host_commit),
    .host_wr_ready  (host_wr_ready),
    .buf_we         (buf_we),
    .buf_waddr      (buf_waddr),
    .buf_bank_sel_wr(buf_bank_sel_wr),
    .cfg_k_len      (cfg_k_len),
    .arr_ready      (arr_ready),
    .rd_en          (rd_en),
    .k_idx          (k_idx),
    .bank_sel_rd    (bank_sel_rd),
    .a_valid        (a_valid),
    .tile_done      (tile_done),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] k;
    logic          bank;
    bit            stream;
    int            gap;     // 0: any, else cycles since previous read
  } rd_exp_t;

  rd_exp_t rd_q[$];
  logic    td_q[$];
  int      av_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a read, a valid row or a release.
  int      cyc = 0;
  int      last_rd = 0;
  rd_exp_t e;
  logic    exp_av;
  logic    exp_bank;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rd_q.delete();
        td_q.delete();
        av_q.delete();
      end else begin
        if (rd_en) begin
          if (rd_q.size() == 0) begin
            chk("rd_en_unexpected", 32'd1, 32'd0);
          end else begin
            e = rd_q.pop_front();
            chk("k_idx", 32'(k_idx), 32'(e.k));
            chk("bank_sel_rd", 32'(bank_sel_rd), 32'(e.bank));
            if (e.gap != 0) chk("rd_gap", 32'(cyc - last_rd), 32'(e.gap));
            last_rd = cyc;
            if (e.stream) av_q.push_back(cyc + 2);
          end
        end
        exp_av = (av_q.size() > 0) && (av_q[0] == cyc);
        if (exp_av) void'(av_q.pop_front());
        if (a_valid || exp_av) chk("a_valid", 32'(a_valid), 32'(exp_av));
        if (tile_done) begin
          if (td_q.size() == 0) begin
            chk("tile_done_unexpected", 32'd1, 32'd0);
          end else begin
            exp_bank = td_q.pop_front();
            chk("release_bank", 32'(bank_sel_rd), 32'(exp_bank));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tile(input logic bank, input int klen, input int first_gap);
    rd_exp_t x;
    for (int i = 0; i < klen; i++) begin
      x.k = AW'(i); x.bank = bank; x.stream = 1'b1; x.gap = (i == 0) ? first_gap : 1;
      rd_q.push_back(x);
    end
    x.k = AW'(klen - 1); x.bank = bank; x.stream = 1'b0; x.gap = 1;
    rd_q.push_back(x);
    td_q.push_back(bank);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((rd_q.size() + td_q.size() + av_q.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= budget) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_rd(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_en && n < budget);
    if (!rd_en) chk("rd_start_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic commit_one();
    host_commit = 1'b1;
    tick();
    host_commit = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_k_idx", 32'(k_idx), 32'd0);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_tile_done", 32'(tile_done), 32'd0);
    chk("rst_err", 32'(err_overflow), 32'd0);
    chk("rst_bank_sel_rd", 32'(bank_sel_rd), 32'd0);
    chk("rst_bank_sel_wr", 32'(buf_bank_sel_wr), 32'd0);
    chk("rst_wr_ready", 32'(host_wr_ready), 32'd1);

    // Single 4-row tile from bank 0
    for (int i = 0; i < 4; i++) begin
      host_we = 1'b1;
      host_waddr = AW'(i);
      #1;
      chk("wr_buf_we", 32'(buf_we), 32'd1);
      chk("wr_buf_waddr", 32'(buf_waddr), 32'(i));
      chk("wr_bank_sel", 32'(buf_bank_sel_wr), 32'd0);
      tick();
    end
    host_we = 1'b0;
    cfg_k_len = 8'd4;
    push_tile(1'b0, 4, 0);
    commit_one();
    arr_ready = 1'b1;
    wait_idle(50);
    chk("tile1_wr_ready", 32'(host_wr_ready), 32'd1);
    arr_ready = 1'b0;

    // Overflow: both banks full, then write and commit attempts
    host_commit = 1'b1;
    tick();
    tick();
    host_commit = 1'b0;
    chk("ovf_wr_ready", 32'(host_wr_ready), 32'd0);
    chk("ovf_err_before", 32'(err_overflow), 32'd0);
    host_we = 1'b1;
    host_waddr = 7'd5;
    #1;
    chk("ovf_buf_we", 32'(buf_we), 32'd0);
    tick();
    host_we = 1'b0;
    chk("ovf_err_set", 32'(err_overflow), 32'd1);
    commit_one();
    chk("ovf_commit_ignored", 32'(host_wr_ready), 32'd0);
    tick();
    chk("ovf_err_sticky", 32'(err_overflow), 32'd1);

    // Drain both banks back to back: bank 1 then bank 0
    cfg_k_len = 8'd2;
    push_tile(1'b1, 2, 0);
    push_tile(1'b0, 2, 2);
    arr_ready = 1'b1;
    wait_idle(60);
    chk("b2b_wr_ready", 32'(host_wr_ready), 32'd1);
    chk("b2b_err_sticky", 32'(err_overflow), 32'd1);
    arr_ready = 1'b0;

    do_reset();
    chk("rst2_err", 32'(err_overflow), 32'd0);
    chk("rst2_bank_sel_wr", 32'(buf_bank_sel_wr), 32'd0);

    // Commit of bank 1 coincides with the release of bank 0
    arr_ready = 1'b1;
    cfg_k_len = 8'd3;
    push_tile(1'b0, 3, 0);
    commit_one();
    wait_rd(20);
    repeat (3) @(posedge clk);
    #1;
    host_commit = 1'b1;
    cfg_k_len = 8'd1;
    push_tile(1'b1, 1, 2);
    tick();
    host_commit = 1'b0;
    chk("sim_wr_ready", 32'(host_wr_ready), 32'd1);
    chk("sim_bank_sel_wr", 32'(buf_bank_sel_wr), 32'd0);
    wait_idle(40);
    chk("sim_bank_sel_wr_end", 32'(buf_bank_sel_wr), 32'd0);
    arr_ready = 1'b0;

    // Zero-length tile releases bank 0 without reading
    cfg_k_len = 8'd0;
    commit_one();
    tick();
    td_q.push_back(1'b0);
    arr_ready = 1'b1;
    tick();
    arr_ready = 1'b0;
    chk("zero_td_seen", 32'(td_q.size()), 32'd0);
    commit_one();
    chk("zero_bank_freed", 32'(host_wr_ready), 32'd1);

    // Oversized length clamps to the full 128-row depth, bank 1
    cfg_k_len = 8'd200;
    push_tile(1'b1, 128, 0);
    arr_ready = 1'b1;
    wait_idle(300);
    arr_ready = 1'b0;

    // Reset in the middle of a tile
    cfg_k_len = 8'd4;
    push_tile(1'b0, 4, 0);
    commit_one();
    arr_ready = 1'b1;
    wait_rd(20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_k_idx", 32'(k_idx), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rd_en", 32'(rd_en), 32'd0);
    chk("mid_wr_ready", 32'(host_wr_ready), 32'd1);
    chk("mid_tile_done", 32'(tile_done), 32'd0);
    chk("mid_a_valid", 32'(a_valid), 32'd0);
    repeat (6) tick();
    arr_ready = 1'b0;
    chk("queues_empty", 32'(rd_q.size() + td_q.size() + av_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
